// File: rtl/fifo_guard_if.sv
// Handshake bundle for fifo_guard: write/read requests, data, status and
// error-reporting signals. The slave modport is the FIFO side.
interface fifo_guard_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;
    logic [7:0]       drop_cnt;
    logic             err_clr;

    modport master (
        output wr_en, wr_data, rd_en, err_clr,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow, drop_cnt
    );

    modport slave (
        input  wr_en, wr_data, rd_en, err_clr,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow, drop_cnt
    );
endinterface

// File: rtl/fifo_guard.sv
// Synchronous FIFO that blocks reads on empty and writes on full, records
// each rejected request in sticky flags plus a saturating drop counter,
// and offers almost-full/almost-empty thresholds and a read-valid strobe.
module fifo_guard #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    fifo_guard_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    logic             full_s, empty_s;
    logic             wr_acc_s, rd_acc_s;
    logic             wr_rej_s, rd_rej_s;
    logic [1:0]       rej_n_s;
    logic [8:0]       drop_sum_s;

    // Status flags decode from the count register only, so they change
    // only on clock edges; acceptance uses these registered flags, so a
    // same-cycle write never makes an empty FIFO readable.
    always_comb begin
        full_s     = (count_q == CW'(DEPTH));
        empty_s    = (count_q == CW'(0));
        rd_acc_s   = bus.rd_en & ~empty_s;
        wr_acc_s   = bus.wr_en & (~full_s | rd_acc_s);
        wr_rej_s   = bus.wr_en & ~wr_acc_s;
        rd_rej_s   = bus.rd_en & ~rd_acc_s;
        rej_n_s    = {1'b0, wr_rej_s} + {1'b0, rd_rej_s};
        drop_sum_s = {1'b0, drop_cnt_q} + {7'b0, rej_n_s};
    end

    // Next-state for pointers, occupancy, read port and error tracking.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = rd_acc_s;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        drop_cnt_d  = drop_cnt_q;

        if (wr_acc_s) begin
            wptr_d = wptr_q + PW'(1);
        end else begin
            wptr_d = wptr_q;
        end

        if (rd_acc_s) begin
            rptr_d    = rptr_q + PW'(1);
            rd_data_d = mem_q[rptr_q];
        end else begin
            rptr_d    = rptr_q;
            rd_data_d = rd_data_q;
        end

        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A rejection in the same cycle as a clear survives the clear.
        if (bus.err_clr) begin
            overflow_d  = wr_rej_s;
            underflow_d = rd_rej_s;
            drop_cnt_d  = {6'b0, rej_n_s};
        end else begin
            overflow_d  = overflow_q | wr_rej_s;
            underflow_d = underflow_q | rd_rej_s;
            if (drop_sum_s > 9'd255) begin
                drop_cnt_d = 8'hFF;
            end else begin
                drop_cnt_d = drop_sum_s[7:0];
            end
        end
    end

    // Control and status registers; asynchronous reset discards all state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            drop_cnt_q  <= 8'h00;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Storage array; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_q[wptr_q] <= bus.wr_data;
        end
    end

    assign bus.rd_data      = rd_data_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.full         = full_s;
    assign bus.empty        = empty_s;
    assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
    assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
    assign bus.drop_cnt     = drop_cnt_q;
endmodule

// File: tb/tb_fifo_guard.sv
// Directed self-checking bench for fifo_guard (WIDTH=8, DEPTH=16).
module tb_fifo_guard;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    fifo_guard_if #(.WIDTH(8), .DEPTH(16)) bus ();

    fifo_guard #(.WIDTH(8), .DEPTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle with the given requests; inputs drop back to idle
    // 1 ns after the edge, which is also where outputs are sampled.
    task automatic step(input logic wr, input logic [7:0] wd, input logic rd, input logic clr);
        bus.wr_en   = wr;
        bus.wr_data = wd;
        bus.rd_en   = rd;
        bus.err_clr = clr;
        @(posedge clk);
        #1;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.err_clr = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_count"},   32'(bus.count), 32'd0);
        check({tag, "_empty"},   32'(bus.empty), 32'd1);
        check({tag, "_full"},    32'(bus.full), 32'd0);
        check({tag, "_ae"},      32'(bus.almost_empty), 32'd1);
        check({tag, "_af"},      32'(bus.almost_full), 32'd0);
        check({tag, "_rvalid"},  32'(bus.rd_valid), 32'd0);
        check({tag, "_rdata"},   32'(bus.rd_data), 32'd0);
        check({tag, "_ovf"},     32'(bus.overflow), 32'd0);
        check({tag, "_udf"},     32'(bus.underflow), 32'd0);
        check({tag, "_drop"},    32'(bus.drop_cnt), 32'd0);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.rd_en   = 1'b0;
        bus.err_clr = 1'b0;
        #1;
        check_reset_vals("rst");
        #20;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single write then read.
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        check("w1_count", 32'(bus.count), 32'd1);
        check("w1_empty", 32'(bus.empty), 32'd0);
        check("w1_rvalid", 32'(bus.rd_valid), 32'd0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("r1_rvalid", 32'(bus.rd_valid), 32'd1);
        check("r1_rdata", 32'(bus.rd_data), 32'hA5);
        check("r1_count", 32'(bus.count), 32'd0);
        check("r1_empty", 32'(bus.empty), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("idle_rvalid", 32'(bus.rd_valid), 32'd0);
        check("idle_rdata", 32'(bus.rd_data), 32'hA5);

        // Fill to full, watching almost_full switch on at 14.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            check("fill_count", 32'(bus.count), 32'(i + 1));
            check("fill_af", 32'(bus.almost_full), (i + 1 >= 14) ? 32'd1 : 32'd0);
            check("fill_ae", 32'(bus.almost_empty), (i + 1 <= 2) ? 32'd1 : 32'd0);
        end
        check("fill_full", 32'(bus.full), 32'd1);
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        check("ovf_flag", 32'(bus.overflow), 32'd1);
        check("ovf_drop", 32'(bus.drop_cnt), 32'd1);
        check("ovf_count", 32'(bus.count), 32'd16);
        check("ovf_udf", 32'(bus.underflow), 32'd0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            check("drain_rvalid", 32'(bus.rd_valid), 32'd1);
            check("drain_rdata", 32'(bus.rd_data), 32'(i));
        end
        check("drain_empty", 32'(bus.empty), 32'd1);

        // Refill across the pointer wrap and read back.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        end
        check("wrap_full", 32'(bus.full), 32'd1);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            check("wrap_rdata", 32'(bus.rd_data), 32'(8'h10 + i));
        end
        check("wrap_count", 32'(bus.count), 32'd0);

        // Clear the overflow left over from the fill test.
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("clr1_ovf", 32'(bus.overflow), 32'd0);
        check("clr1_drop", 32'(bus.drop_cnt), 32'd0);

        // Underflow, then simultaneous read+write on empty.
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("udf_flag", 32'(bus.underflow), 32'd1);
        check("udf_drop", 32'(bus.drop_cnt), 32'd1);
        check("udf_rvalid", 32'(bus.rd_valid), 32'd0);
        check("udf_rdata", 32'(bus.rd_data), 32'h1F);
        step(1'b1, 8'h77, 1'b1, 1'b0);
        check("rwe_count", 32'(bus.count), 32'd1);
        check("rwe_udf", 32'(bus.underflow), 32'd1);
        check("rwe_drop", 32'(bus.drop_cnt), 32'd2);
        check("rwe_rvalid", 32'(bus.rd_valid), 32'd0);
        check("rwe_ovf", 32'(bus.overflow), 32'd0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("rwe_rdata", 32'(bus.rd_data), 32'h77);
        check("rwe_empty", 32'(bus.empty), 32'd1);

        // Simultaneous read+write while full.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
            check("rwf_count", 32'(bus.count), 32'd16);
            check("rwf_ovf", 32'(bus.overflow), 32'd0);
            check("rwf_rdata", 32'(bus.rd_data), 32'(8'h40 + i));
            check("rwf_rvalid", 32'(bus.rd_valid), 32'd1);
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            check("rwf_drain", 32'(bus.rd_data), (i < 12) ? 32'(8'h44 + i) : 32'(8'h80 + i - 12));
        end
        check("rwf_empty", 32'(bus.empty), 32'd1);

        // Saturate drop_cnt with illegal reads.
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check("sat_drop", 32'(bus.drop_cnt), 32'd255);
        check("sat_udf", 32'(bus.underflow), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("clr2_drop", 32'(bus.drop_cnt), 32'd0);
        check("clr2_udf", 32'(bus.underflow), 32'd0);
        check("clr2_ovf", 32'(bus.overflow), 32'd0);

        // Clear coinciding with an illegal write: the new event wins.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        end
        step(1'b1, 8'hEE, 1'b0, 1'b1);
        check("clrw_ovf", 32'(bus.overflow), 32'd1);
        check("clrw_drop", 32'(bus.drop_cnt), 32'd1);
        check("clrw_udf", 32'(bus.underflow), 32'd0);
        check("clrw_count", 32'(bus.count), 32'd16);

        // Drain to 9 entries, then pulse reset between edges.
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check("pre_count", 32'(bus.count), 32'd9);
        check("pre_rvalid", 32'(bus.rd_valid), 32'd1);
        check("pre_rdata", 32'(bus.rd_data), 32'hC6);
        rst_n = 1'b0;
        #1;
        check_reset_vals("arst");
        #2;
        rst_n = 1'b1;
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        check("post_count", 32'(bus.count), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("post_rdata", 32'(bus.rd_data), 32'h3C);
        check("post_rvalid", 32'(bus.rd_valid), 32'd1);
        check("post_empty", 32'(bus.empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
